// File: rtl/tlc_pkg.sv
// Shared state encoding, lamp bit positions and lamp decode helpers for the
// multi-phase traffic-light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    IDLE, ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW
  } state_t;

  localparam int LAMP_RED    = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_GREEN  = 2;
  localparam int PED_RED     = 0;
  localparam int PED_GREEN   = 1;

  typedef logic [2:0] car_lamp_t;
  typedef logic [1:0] ped_lamp_t;

  function automatic car_lamp_t car_lamps(input state_t s, input logic act, input logic blink);
    car_lamp_t l;
    l = '0;
    if (s == IDLE) l[LAMP_YELLOW] = blink;
    else if (!act) l[LAMP_RED] = 1'b1;
    else begin
      case (s)
        RED_YELLOW:  begin l[LAMP_RED] = 1'b1; l[LAMP_YELLOW] = 1'b1; end
        GREEN:       l[LAMP_GREEN]  = 1'b1;
        GREEN_BLINK: l[LAMP_GREEN]  = blink;
        YELLOW:      l[LAMP_YELLOW] = 1'b1;
        default:     l[LAMP_RED]    = 1'b1;
      endcase
    end
    return l;
  endfunction

  function automatic ped_lamp_t ped_lamps(input state_t s, input logic act, input logic blink);
    ped_lamp_t l;
    l = '0;
    if (s == IDLE) l = '0;
    else if (act && s == GREEN) l[PED_GREEN] = 1'b1;
    else if (act && s == GREEN_BLINK) l[PED_GREEN] = blink;
    else l[PED_RED] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/tlc_ped_request.sv
// One approach's pedestrian request: optional debounce (TLC_PED_DEBOUNCE_EN),
// latch with clear-on-green and ignore-while-served.
module tlc_ped_request #(
  parameter int DEBOUNCE_MS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1khz,
  input  logic req,
  input  logic ignore,
  input  logic clear,
  output logic pending
);

  logic sample_set;

`ifdef TLC_PED_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  logic [CW-1:0] run;

  // Saturating run length of consecutive high samples; any low sample restarts it.
  always_ff @(posedge clk) begin
    if (rst) run <= '0;
    else if (tick_1khz) begin
      if (!req) run <= '0;
      else if (run != CW'(DEBOUNCE_MS)) run <= run + 1'b1;
    end
  end

  assign sample_set = tick_1khz && req && (run == CW'(DEBOUNCE_MS - 1));
`else
  assign sample_set = tick_1khz && req && (DEBOUNCE_MS > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else if (clear) pending <= 1'b0;
    else if (sample_set && !ignore) pending <= 1'b1;
  end

endmodule

// File: rtl/tlc_intersection.sv
// Multi-phase round-robin traffic-light controller with all-red clearance,
// pedestrian requests and GREEN_BLINK countdown. Debounce via TLC_PED_DEBOUNCE_EN.
module tlc_intersection #(
  parameter int NUM_PHASES   = 2,
  parameter int T_RED_YELLOW = 10,
  parameter int T_GREEN      = 150,
  parameter int T_GREEN_MIN  = 50,
  parameter int T_BLINK      = 40,
  parameter int T_YELLOW     = 30,
  parameter int T_ALL_RED    = 10,
  parameter int BLINK_TICKS  = 5,
  parameter int DEBOUNCE_MS  = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_10hz_i,
  input  logic                  tick_1khz_i,
  input  logic                  enable_i,
  input  logic [NUM_PHASES-1:0] ped_req_i,
  output logic [NUM_PHASES-1:0] car_red_o,
  output logic [NUM_PHASES-1:0] car_yellow_o,
  output logic [NUM_PHASES-1:0] car_green_o,
  output logic [NUM_PHASES-1:0] ped_red_o,
  output logic [NUM_PHASES-1:0] ped_green_o,
  output logic [NUM_PHASES-1:0] ped_pending_o,
  output logic [1:0]            active_phase_o,
  output logic [3:0]            countdown_o,
  output logic                  countdown_valid_o
);
  import tlc_pkg::*;

  localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);
  localparam logic [7:0] AR_END  = 8'(T_ALL_RED - 1);
  localparam logic [7:0] RY_END  = 8'(T_RED_YELLOW - 1);
  localparam logic [7:0] G_END   = 8'(T_GREEN - 1);
  localparam logic [7:0] G_MIN   = 8'(T_GREEN_MIN - 1);
  localparam logic [7:0] GB_END  = 8'(T_BLINK - 1);
  localparam logic [7:0] Y_END   = 8'(T_YELLOW - 1);
  localparam logic [7:0] BL_END  = 8'(BLINK_TICKS - 1);
  localparam logic [3:0] CD_DIG  = 4'((T_BLINK - 1) / 10);
  localparam logic [3:0] CD_SUB  = 4'((T_BLINK - 1) % 10);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, bcnt, bcnt_n;
  logic       blink, blink_n;
  logic [1:0] phase, phase_n;
  logic [3:0] digit, digit_n, sub, sub_n;
  logic [NUM_PHASES-1:0] other, clear_req, ignore_req;
  logic       other_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; cnt <= '0; bcnt <= '0; blink <= 1'b0;
      phase <= '0;   digit <= '0; sub <= '0;
    end else begin
      state <= state_n; cnt <= cnt_n; bcnt <= bcnt_n; blink <= blink_n;
      phase <= phase_n; digit <= digit_n; sub <= sub_n;
    end
  end

  always_comb begin
    state_n = state; cnt_n = cnt; bcnt_n = bcnt; blink_n = blink;
    phase_n = phase; digit_n = digit; sub_n = sub;
    if (!enable_i) begin
      if (state != IDLE) begin
        state_n = IDLE; cnt_n = '0; bcnt_n = '0; blink_n = 1'b0;
      end else if (tick_10hz_i) begin
        if (bcnt == BL_END) begin bcnt_n = '0; blink_n = ~blink; end
        else bcnt_n = bcnt + 8'd1;
      end
    end else if (tick_10hz_i) begin
      cnt_n = cnt + 8'd1;
      case (state)
        IDLE: begin state_n = ALL_RED; cnt_n = '0; phase_n = LAST_PHASE; end
        ALL_RED: if (cnt == AR_END) begin
          state_n = RED_YELLOW; cnt_n = '0;
          phase_n = (phase == LAST_PHASE) ? 2'd0 : phase + 2'd1;
        end
        RED_YELLOW: if (cnt == RY_END) begin state_n = GREEN; cnt_n = '0; end
        // A waiting pedestrian on another approach cuts green short once the minimum has run.
        GREEN: if (cnt == G_END || (other_pend && cnt >= G_MIN)) begin
          state_n = GREEN_BLINK; cnt_n = '0; bcnt_n = '0; blink_n = 1'b1;
          digit_n = CD_DIG; sub_n = CD_SUB;
        end
        GREEN_BLINK: begin
          if (bcnt == BL_END) begin bcnt_n = '0; blink_n = ~blink; end
          else bcnt_n = bcnt + 8'd1;
          if (sub == 4'd0) begin sub_n = 4'd9; digit_n = digit - 4'd1; end
          else sub_n = sub - 4'd1;
          if (cnt == GB_END) begin state_n = YELLOW; cnt_n = '0; end
        end
        YELLOW: if (cnt == Y_END) begin state_n = ALL_RED; cnt_n = '0; end
        default: begin state_n = IDLE; cnt_n = '0; end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
    logic      act;
    car_lamp_t car;
    ped_lamp_t ped;

    assign act           = (phase == 2'(i));
    assign other[i]      = ped_pending_o[i] && !act;
    assign ignore_req[i] = act && (state == GREEN || state == GREEN_BLINK);
    assign clear_req[i]  = (state_n == GREEN) && (state != GREEN) && (phase_n == 2'(i));

    tlc_ped_request #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_req (
      .clk       (clk),
      .rst       (rst),
      .tick_1khz (tick_1khz_i),
      .req       (ped_req_i[i]),
      .ignore    (ignore_req[i]),
      .clear     (clear_req[i]),
      .pending   (ped_pending_o[i])
    );

    assign car             = car_lamps(state, act, blink);
    assign ped             = ped_lamps(state, act, blink);
    assign car_red_o[i]    = car[LAMP_RED];
    assign car_yellow_o[i] = car[LAMP_YELLOW];
    assign car_green_o[i]  = car[LAMP_GREEN];
    assign ped_red_o[i]    = ped[PED_RED];
    assign ped_green_o[i]  = ped[PED_GREEN];
  end

  assign other_pend        = |other;
  assign active_phase_o    = phase;
  assign countdown_valid_o = (state == GREEN_BLINK);
  assign countdown_o       = countdown_valid_o ? digit : 4'd0;

endmodule

// File: tb/tb_tlc_intersection.sv
// Directed bench: 2-phase controller timing/requests/idle, plus a 4-phase
// instance checked for round-robin order, single green and all-red gaps.
module tb_tlc_intersection;

  logic clk = 1'b0;
  logic rst, t10, t1k, en, en4;
  logic [1:0] ped;
  logic [1:0] cr, cy, cg, pr, pg, pend, phase;
  logic [3:0] cd;
  logic       cdv;
  logic [3:0] cr4, cy4, cg4, pr4, pg4, pend4, ped4_unused_in;
  logic [1:0] phase4;
  logic [3:0] cd4;
  logic       cdv4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ped4_unused_in = 4'b0000;

  tlc_intersection u_dut (
    .clk(clk), .rst(rst), .tick_10hz_i(t10), .tick_1khz_i(t1k), .enable_i(en),
    .ped_req_i(ped), .car_red_o(cr), .car_yellow_o(cy), .car_green_o(cg),
    .ped_red_o(pr), .ped_green_o(pg), .ped_pending_o(pend),
    .active_phase_o(phase), .countdown_o(cd), .countdown_valid_o(cdv)
  );

  tlc_intersection #(.NUM_PHASES(4)) u_dut4 (
    .clk(clk), .rst(rst), .tick_10hz_i(t10), .tick_1khz_i(t1k), .enable_i(en4),
    .ped_req_i(ped4_unused_in), .car_red_o(cr4), .car_yellow_o(cy4), .car_green_o(cg4),
    .ped_red_o(pr4), .ped_green_o(pg4), .ped_pending_o(pend4),
    .active_phase_o(phase4), .countdown_o(cd4), .countdown_valid_o(cdv4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lamps packed as {car_red, car_yellow, car_green, ped_red, ped_green}.
  task automatic chk_l(input string tag, input logic [1:0] ecr, input logic [1:0] ecy,
                       input logic [1:0] ecg, input logic [1:0] epr, input logic [1:0] epg);
    chk(tag, {22'd0, cr, cy, cg, pr, pg}, {22'd0, ecr, ecy, ecg, epr, epg});
  endtask

  task automatic step(input logic a, input logic b);
    @(negedge clk); t10 = a; t1k = b;
    @(posedge clk); #1; t10 = 1'b0; t1k = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic hold_ped(input logic [1:0] v, input int ms);
    ped = v;
    repeat (ms) step(1'b0, 1'b1);
    ped = 2'b00;
  endtask

  initial begin
    logic [1:0] prev4;
    logic [2:0] seq [6];
    int nchg, run, maxg, minrun, maxrun;
    rst = 1'b1; en = 1'b0; en4 = 1'b0; ped = 2'b00; t10 = 1'b0; t1k = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    chk_l("reset_lamps", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("reset_pending", pend, 0);
    chk("reset_phase", phase, 0);
    chk("reset_countdown", {cdv, cd}, 0);
    rst = 1'b0;

    // Flashing-yellow idle
    ticks(4); chk_l("idle_off", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    ticks(1); chk_l("idle_on", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    ticks(5); chk_l("idle_off2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Start-up: ALL_RED with last phase, phase 0 first
    en = 1'b1; step(1'b0, 1'b0);
    chk_l("idle_wait_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("all_red", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00); chk("start_phase", phase, 1);
    ticks(9);  chk_l("all_red_last", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    ticks(1);  chk_l("red_yellow0", 2'b11, 2'b01, 2'b00, 2'b11, 2'b00); chk("phase0", phase, 0);
    ticks(9);  chk_l("red_yellow0_last", 2'b11, 2'b01, 2'b00, 2'b11, 2'b00);
    ticks(1);  chk_l("green0", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
    ticks(149); chk_l("green0_last", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
    chk("cd_before_blink", {cdv, cd}, 0);
    ticks(1);  chk_l("blink0_on", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01); chk("cd_load", {cdv, cd}, 5'h13);
    ticks(4);  chk_l("blink0_on_last", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
    ticks(1);  chk_l("blink0_off", 2'b10, 2'b00, 2'b00, 2'b10, 2'b00); chk("cd_3", {cdv, cd}, 5'h13);
    ticks(5);  chk_l("blink0_on2", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01); chk("cd_2", {cdv, cd}, 5'h12);
    ticks(20); chk("cd_0", {cdv, cd}, 5'h10);
    ticks(9);  chk("cd_0_last", {cdv, cd}, 5'h10);
    ticks(1);  chk_l("yellow0", 2'b10, 2'b01, 2'b00, 2'b11, 2'b00); chk("cd_invalid", {cdv, cd}, 0);
    ticks(29); chk_l("yellow0_last", 2'b10, 2'b01, 2'b00, 2'b11, 2'b00);
    ticks(1);  chk_l("clear0", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00); chk("clear_phase", phase, 0);
    ticks(10); chk_l("red_yellow1", 2'b11, 2'b10, 2'b00, 2'b11, 2'b00); chk("phase1", phase, 1);
    ticks(10); chk_l("green1", 2'b01, 2'b00, 2'b10, 2'b01, 2'b10);

    // Own-phase request ignored while served
    hold_ped(2'b10, 60); chk("ignore_active", pend, 2'b00);
    ticks(150); chk("green1_full", cdv, 1'b1);
    ticks(90);  chk_l("green0_again", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);

    // Request at green tick 10 shortens green to T_GREEN_MIN
    ticks(10); hold_ped(2'b10, 60);
    chk("req1_latched", pend, 2'b10);
    ticks(39); chk_l("short_green_last", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
    ticks(1);  chk("short_green_exit", cdv, 1'b1);
    ticks(80); chk("req1_held", pend, 2'b10);
    ticks(10); chk("req1_cleared", pend, 2'b00); chk_l("green1_b", 2'b01, 2'b00, 2'b10, 2'b01, 2'b10);

    // Request after the minimum: exit on next tick
    ticks(60); hold_ped(2'b01, 60);
    chk("req0_latched", pend, 2'b01);
    chk_l("late_req_wait", 2'b01, 2'b00, 2'b10, 2'b01, 2'b10);
    ticks(1);  chk("late_req_exit", cdv, 1'b1);
    ticks(90); chk("req0_cleared", pend, 2'b00); chk_l("green0_b", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);

    // Drop enable mid-green: IDLE at once, flash, requests kept
    ticks(20); en = 1'b0; step(1'b0, 1'b0);
    chk_l("drop_enable", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); chk("drop_cd", {cdv, cd}, 0);
    ticks(5); chk_l("drop_flash_on", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    ticks(5); chk_l("drop_flash_off", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    hold_ped(2'b10, 30);
`ifdef TLC_PED_DEBOUNCE_EN
    chk("short_pulse", pend, 2'b00);
`else
    chk("short_pulse", pend, 2'b10);
`endif
    hold_ped(2'b01, 60);
`ifdef TLC_PED_DEBOUNCE_EN
    chk("idle_req_kept", pend, 2'b01);
`else
    chk("idle_req_kept", pend, 2'b11);
`endif
    en = 1'b1;
    ticks(1);  chk_l("reenable_all_red", 2'b11, 2'b00, 2'b00, 2'b11, 2'b00); chk("reenable_phase", phase, 1);
    ticks(20); chk_l("reenable_green0", 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
`ifdef TLC_PED_DEBOUNCE_EN
    chk("reenable_pending", pend, 2'b00);
`else
    chk("reenable_pending", pend, 2'b10);
`endif

    // Four-phase instance
    en = 1'b0; rst = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0); rst = 1'b0;
    chk("u4_reset_phase", phase4, 0);
    en4 = 1'b1;
    prev4 = phase4; nchg = 0; run = 0; maxg = 0; minrun = 255; maxrun = 0;
    for (int k = 0; k < 1200 && nchg < 6; k++) begin
      step(1'b1, 1'b0);
      if ($countones(cg4) > maxg) maxg = $countones(cg4);
      if (phase4 != prev4) begin
        seq[nchg] = {1'b0, phase4};
        if (nchg > 0) begin
          if (run < minrun) minrun = run;
          if (run > maxrun) maxrun = run;
        end
        nchg++;
        prev4 = phase4;
      end
      if (cr4 == 4'hF && cy4 == 4'h0 && cg4 == 4'h0) run++;
      else run = 0;
    end
    chk("u4_changes", nchg, 6);
    chk("u4_order", {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]},
        {3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0});
    chk("u4_max_green", maxg, 1);
    chk("u4_all_red_min", minrun, 10);
    chk("u4_all_red_max", maxrun, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
